// File: rtl/afifo_rd_packer.sv
// rtl/afifo_rd_packer.sv - packs narrow fast-read FIFO entries into wide words with lane enables
// Partial words leave on an idle timeout or a flush request so trailing bytes are never stranded.
module afifo_rd_packer #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int TMO_W = 8
) (
  input  logic                     rd_clk,
  input  logic                     rd_reset,
  input  logic                     fifo_empty,
  input  logic [IN_W-1:0]          fifo_rd_data,
  output logic                     fifo_rd_en,
  input  logic [TMO_W-1:0]         cfg_tmo,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [OUT_W/IN_W-1:0]    out_be,
  output logic                     busy
);

  localparam int N   = OUT_W / IN_W;
  localparam int LCW = $clog2(N);
  localparam logic [LCW-1:0] LAST_LANE = LCW'(N - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_HOLD = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_acc_data;
  logic [N-1:0]     r_acc_be;
  logic [LCW-1:0]   r_lane_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [OUT_W-1:0] r_out_data;
  logic [N-1:0]     r_out_be;
  logic             r_out_valid;

  logic             w_out_free;
  logic             w_pop;
  logic             w_last;
  logic             w_tmo_hit;
  logic             w_flush;
  logic             w_load;
  logic [OUT_W-1:0] w_acc_data;
  logic [N-1:0]     w_acc_be;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_tmo_hit  = (cfg_tmo != '0) && (r_tmo_cnt == cfg_tmo);

  // Accumulator with the byte popped this cycle already merged in, so a
  // same-cycle flush or completion carries it.
  always_comb begin
    w_acc_data = r_acc_data;
    w_acc_be   = r_acc_be;
    if (w_pop) begin
      w_acc_data[r_lane_cnt*IN_W +: IN_W] = fifo_rd_data;
      w_acc_be[r_lane_cnt]                = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = w_last ? S_IDLE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else if (w_flush) begin
          w_state_nxt = w_out_free ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_out_free) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop   = !rd_reset && !fifo_empty && (r_state != S_HOLD) &&
              ((r_lane_cnt != LAST_LANE) || w_out_free);
    w_last  = w_pop && (r_lane_cnt == LAST_LANE);
    w_flush = (r_state == S_FILL) && (flush_req || w_tmo_hit);
    w_load  = w_last || (w_flush && w_out_free) || ((r_state == S_HOLD) && w_out_free);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      r_acc_data  <= '0;
      r_acc_be    <= '0;
      r_lane_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_out_data  <= '0;
      r_out_be    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_acc_data;
        r_out_be    <= w_acc_be;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      // Clearing on load keeps unfilled lanes of the next partial word at zero.
      if (w_load) begin
        r_acc_data <= '0;
        r_acc_be   <= '0;
        r_lane_cnt <= '0;
      end else if (w_pop) begin
        r_acc_data <= w_acc_data;
        r_acc_be   <= w_acc_be;
        r_lane_cnt <= r_lane_cnt + 1'b1;
      end

      if (w_pop || (r_state == S_IDLE)) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_FILL) && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign fifo_rd_en = w_pop;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_be     = r_out_be;
  assign busy       = (r_state != S_IDLE) || r_out_valid;

endmodule

// File: doc/afifo_rd_packer.md
Name: afifo_rd_packer

Overview:
Read-clock-domain consumer placed directly downstream of the async FIFO, which runs in fast-read mode (read data valid combinationally whenever empty is low). It pops narrow FIFO entries and packs them little-endian into wide words. Each word goes out on a valid/ready interface with per-lane byte enables. A partial word is flushed on an idle timeout or on an explicit flush request, so trailing bytes are never stranded.

Parameters:
IN_W, 8, FIFO entry width in bits.
OUT_W, 32, output word width in bits; must be an integer multiple N = OUT_W/IN_W, with N in 2..8.
TMO_W, 8, width of the timeout configuration and counter.

Ports:
rd_clk  input  1  block clock; same clock as the FIFO read side.
rd_reset  input  1  reset; synchronous, active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_data  input  IN_W  FIFO head entry; valid when fifo_empty=0.
fifo_rd_en  output  1  pop strobe to the FIFO.
cfg_tmo  input  TMO_W  idle cycles before a partial flush; 0 disables the timeout.
flush_req  input  1  single-cycle request to flush the current partial word.
out_valid  output  1  output word valid.
out_ready  input  1  downstream accept.
out_data  output  OUT_W  packed word; lane 0 is bits [IN_W-1:0].
out_be  output  N  lane enables; bit k set means lane k holds data.
busy  output  1  partial data is held or an output word is pending.

Behaviour:
- Reset (rd_reset=1 at the rd_clk edge):
  - out_valid=0, out_data=0, out_be=0, fifo_rd_en=0, busy=0.
  - lane count=0, timeout count=0, state=IDLE.
  - Partial bytes are discarded. Reset mid-operation behaves identically.
- Internal state: accumulator (OUT_W bits plus N-bit lane mask), lane_cnt (0..N-1), output register.
- out_free = !out_valid || out_ready.
- fifo_rd_en (combinational) = !fifo_empty && state!=HOLD && (lane_cnt<N-1 || out_free).
  - Never asserted while fifo_empty=1. The bench must never trigger the FIFO underflow error.
- Pop: the byte in fifo_rd_data is written to lane lane_cnt; lane_cnt increments.
  - If the pop fills lane N-1, the full word (be all ones) loads the output register at the same edge.
  - out_valid rises the cycle after the last pop. The accumulator returns to IDLE with lane_cnt=0.
- States:
  - IDLE: lane_cnt=0.
    - Pop -> FILL, or straight back to IDLE when N lanes are completed.
    - flush_req is ignored in this state.
  - FILL: 0<lane_cnt<N.
    - Pop -> FILL, or IDLE when the word is completed.
    - A flush condition goes to IDLE when out_free, otherwise to HOLD.
  - HOLD: a flush is pending and the output is occupied.
    - No pops.
    - When out_free, the partial word loads the output register -> IDLE.
- Flush condition (evaluated only in FILL) = flush_req || (cfg_tmo!=0 && tmo_cnt==cfg_tmo).
  - The flushed word carries out_be = lane mask. Unfilled lanes of out_data are 0.
- Flush and pop in the same cycle: the popped byte is included first. The flushed word then contains it, and out_be includes its lane.
  - If that pop completes the word, it is a normal full word, with no extra empty flush.
- Timeout counter:
  - Cleared on every pop and whenever state=IDLE.
  - Otherwise increments once per cycle in FILL and saturates at all ones.
  - The flush fires on the cycle the count equals cfg_tmo, i.e. cfg_tmo idle cycles after the last pop.
  - In HOLD the counter holds its value.
- Output handshake:
  - out_data and out_be stay stable while out_valid && !out_ready.
  - A transfer occurs on out_valid && out_ready. A new word may load in the same cycle (back-to-back throughput: one word per N pops).
- busy = (state!=IDLE) || out_valid.
- cfg_tmo is sampled every cycle. Changing it mid-FILL takes effect immediately against the current count.

Test Plan:
- N=4, push 0x11,0x22,0x33,0x44, out_ready=1 -> four consecutive fifo_rd_en pulses. out_valid high one cycle after the 4th pop with out_data=0x44332211, out_be=0xF.
- out_ready=0, 8 entries in the FIFO -> first word is held stable.
  - Exactly 3 more pops occur, then fifo_rd_en stays 0.
  - Raise out_ready -> the 4th pop lands in the same cycle as the transfer; the second word follows.
- cfg_tmo=5, push 0xAA,0xBB then stop -> out_valid 5 idle cycles after the second pop, with out_data=0x0000BBAA, out_be=0x3, busy dropping after the transfer.
- flush_req asserted in the same cycle as the pop of the 3rd byte (0x01,0x02,0x03) -> out_data=0x00030201, out_be=0x7.
  - flush_req while IDLE -> no output.
- flush with out_valid stuck (out_ready=0) -> state HOLD, no pops despite fifo_empty=0. Release out_ready -> partial word emitted, then normal packing resumes.
- rd_reset pulsed after 2 bytes popped -> all outputs 0 next cycle. The next 4 pops yield a word containing only the new bytes with out_be=0xF.
